// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 program loader and the core's unified memory.
package mips32_pkg;

   localparam int          ADDR_W    = 11;
   localparam int          MEM_DEPTH = 2024;
   localparam logic [7:0]  SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_BASE_H = 3'd1,
      ST_BASE_L = 3'd2,
      ST_CNT_H  = 3'd3,
      ST_CNT_L  = 3'd4,
      ST_DATA   = 3'd5,
      ST_CHK    = 3'd6,
      ST_START  = 3'd7
   } loader_state_e;

   // One past the last word a frame would touch; 17 bits so it cannot wrap.
   function automatic logic [16:0] range_end(input logic [ADDR_W-1:0] base,
                                             input logic [15:0]        cnt);
      return {{(17-ADDR_W){1'b0}}, base} + {1'b0, cnt};
   endfunction

endpackage

// File: rtl/mips32_prog_loader_if.sv
// Byte-stream input, memory write port and core start signals of the loader.
interface mips32_prog_loader_if
   import mips32_pkg::*;
();
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_start;
   logic [31:0]       cpu_pc;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata, cpu_start, cpu_pc, busy, done, err
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata, cpu_start, cpu_pc, busy, done, err
   );
endinterface

// File: rtl/mips32_word_assembler.sv
// Packs four accepted bytes, MSB first, into a big-endian 32-bit word.
module mips32_word_assembler
   import mips32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clear,
   input  logic        i_byte_valid,
   input  logic [7:0]  i_byte,
   output logic        o_word_valid,
   output logic [31:0] o_word
);
   logic [1:0]  r_idx;
   logic [23:0] r_shift;

   assign o_word_valid = i_byte_valid & (r_idx == 2'd3);
   assign o_word       = {r_shift, i_byte};

   // Byte index and the three most recent bytes of the current word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx   <= 2'd0;
         r_shift <= 24'd0;
      end else if (i_clear) begin
         r_idx   <= 2'd0;
         r_shift <= 24'd0;
      end else if (i_byte_valid) begin
         r_idx   <= r_idx + 2'd1;
         r_shift <= {r_shift[15:0], i_byte};
      end else begin
         r_idx   <= r_idx;
         r_shift <= r_shift;
      end
   end
endmodule

// File: rtl/mips32_prog_loader.sv
// Frame parser that writes a program into the core's memory and then releases the core.
module mips32_prog_loader
   import mips32_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   mips32_prog_loader_if.master bus
);
   localparam logic [16:0] DEPTH_17 = 17'(MEM_DEPTH);

   loader_state_e     r_state, w_state_next;
   logic              r_in_ready, r_mem_we, r_cpu_start, r_busy, r_done, r_err;
   logic [ADDR_W-1:0] r_mem_addr, r_wr_addr, r_base;
   logic [ADDR_W-9:0] r_base_h;
   logic [31:0]       r_mem_wdata, r_cpu_pc;
   logic [7:0]        r_cnt_h, r_chk;
   logic [15:0]       r_words_left;
   logic              w_accept, w_sync, w_range_err, w_chk_err, w_go_start;
   logic              w_asm_valid, w_asm_clear, w_word_valid;
   logic [31:0]       w_word;
   logic [15:0]       w_cnt;
   logic [16:0]       w_end;

   assign w_accept    = bus.in_valid & r_in_ready;
   assign w_sync      = w_accept & (r_state == ST_IDLE) & (bus.in_data == SYNC_BYTE);
   assign w_cnt       = {r_cnt_h, bus.in_data};
   assign w_end       = range_end(r_base, w_cnt);
   assign w_asm_valid = w_accept & (r_state == ST_DATA);
   assign w_asm_clear = (r_state != ST_DATA);

   mips32_word_assembler u_asm (
      .clk          (clk),
      .rst          (rst),
      .i_clear      (w_asm_clear),
      .i_byte_valid (w_asm_valid),
      .i_byte       (bus.in_data),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );

   // Next-state decode plus the error/start strobes it implies.
   always_comb begin
      w_state_next = r_state;
      w_range_err  = 1'b0;
      w_chk_err    = 1'b0;
      w_go_start   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_sync) w_state_next = ST_BASE_H;
            else        w_state_next = ST_IDLE;
         end
         ST_BASE_H: begin
            if (w_accept) w_state_next = ST_BASE_L;
            else          w_state_next = ST_BASE_H;
         end
         ST_BASE_L: begin
            if (w_accept) w_state_next = ST_CNT_H;
            else          w_state_next = ST_BASE_L;
         end
         ST_CNT_H: begin
            if (w_accept) w_state_next = ST_CNT_L;
            else          w_state_next = ST_CNT_H;
         end
         ST_CNT_L: begin
            if (!w_accept) begin
               w_state_next = ST_CNT_L;
            end else if (w_end > DEPTH_17) begin
               w_range_err  = 1'b1;
               w_state_next = ST_IDLE;
            end else if (w_cnt == 16'd0) begin
               w_state_next = ST_CHK;
            end else begin
               w_state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_word_valid && (r_words_left == 16'd1)) w_state_next = ST_CHK;
            else                                          w_state_next = ST_DATA;
         end
         ST_CHK: begin
            if (!w_accept) begin
               w_state_next = ST_CHK;
            end else if (bus.in_data == r_chk) begin
               w_go_start   = 1'b1;
               w_state_next = ST_START;
            end else begin
               w_chk_err    = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         ST_START: w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // Header capture, checksum accumulation and the write pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_base_h     <= '0;
         r_base       <= '0;
         r_cnt_h      <= 8'd0;
         r_chk        <= 8'd0;
         r_words_left <= 16'd0;
         r_wr_addr    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_sync) r_chk <= 8'd0;
               else        r_chk <= r_chk;
            end
            ST_BASE_H: begin
               if (w_accept) begin
                  r_base_h <= bus.in_data[ADDR_W-9:0];
                  r_chk    <= r_chk ^ bus.in_data;
               end else begin
                  r_base_h <= r_base_h;
               end
            end
            ST_BASE_L: begin
               if (w_accept) begin
                  r_base <= {r_base_h, bus.in_data};
                  r_chk  <= r_chk ^ bus.in_data;
               end else begin
                  r_base <= r_base;
               end
            end
            ST_CNT_H: begin
               if (w_accept) begin
                  r_cnt_h <= bus.in_data;
                  r_chk   <= r_chk ^ bus.in_data;
               end else begin
                  r_cnt_h <= r_cnt_h;
               end
            end
            ST_CNT_L: begin
               if (w_accept) begin
                  r_words_left <= w_cnt;
                  r_wr_addr    <= r_base;
                  r_chk        <= r_chk ^ bus.in_data;
               end else begin
                  r_words_left <= r_words_left;
               end
            end
            ST_DATA: begin
               if (w_accept) r_chk <= r_chk ^ bus.in_data;
               else          r_chk <= r_chk;
               if (w_word_valid) begin
                  r_wr_addr    <= r_wr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                  r_words_left <= r_words_left - 16'd1;
               end else begin
                  r_wr_addr    <= r_wr_addr;
               end
            end
            default: r_chk <= r_chk;
         endcase
      end
   end

   // Registered outputs toward the stream source, memory and core.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_in_ready  <= 1'b1;
         r_busy      <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 32'd0;
         r_cpu_start <= 1'b0;
         r_cpu_pc    <= 32'd0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_in_ready  <= (w_state_next != ST_START);
         r_busy      <= (w_state_next != ST_IDLE);
         r_mem_we    <= w_word_valid;
         r_cpu_start <= w_go_start;
         if (w_word_valid) begin
            r_mem_addr  <= r_wr_addr;
            r_mem_wdata <= w_word;
         end else begin
            r_mem_addr  <= r_mem_addr;
         end
         if (w_go_start) r_cpu_pc <= {{(32-ADDR_W){1'b0}}, r_base};
         else            r_cpu_pc <= r_cpu_pc;
         if (w_sync) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
         end else begin
            r_done <= r_done | w_go_start;
            r_err  <= r_err | w_range_err | w_chk_err;
         end
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.cpu_start = r_cpu_start;
   assign bus.cpu_pc    = r_cpu_pc;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.err       = r_err;
endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for the program loader: framing, checksum, range and reset cases.
module tb_mips32_prog_loader;
   import mips32_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   logic [31:0]       words [0:15];
   logic [ADDR_W-1:0] wr_addr_q [$];
   logic [31:0]       wr_data_q [$];
   int                wr_cyc_q  [$];
   int                start_cnt = 0;
   int                start_cyc = 0;
   logic [31:0]       start_pc  = 32'd0;
   int                w0, s0;

   mips32_prog_loader_if bus();

   mips32_prog_loader dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Observe writes and start pulses away from the active edge.
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         wr_addr_q.push_back(bus.mem_addr);
         wr_data_q.push_back(bus.mem_wdata);
         wr_cyc_q.push_back(cyc);
      end
      if (bus.cpu_start === 1'b1) begin
         start_cnt = start_cnt + 1;
         start_cyc = cyc;
         start_pc  = bus.cpu_pc;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (!bus.in_ready && n < 16) begin
         @(negedge clk);
         n++;
      end
      if (n >= 16) check_val("in_ready_wait", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] base, input logic [15:0] cnt,
                             input int first, input logic [7:0] flip, input int gap);
      logic [7:0] c;
      logic [31:0] w;
      c = base[15:8] ^ base[7:0] ^ cnt[15:8] ^ cnt[7:0];
      send_byte(SYNC_BYTE, gap);
      send_byte(base[15:8], gap);
      send_byte(base[7:0], gap);
      send_byte(cnt[15:8], gap);
      send_byte(cnt[7:0], gap);
      for (int i = 0; i < int'(cnt); i++) begin
         w = words[first + i];
         for (int k = 3; k >= 0; k--) begin
            send_byte(w[k*8 +: 8], gap);
            c = c ^ w[k*8 +: 8];
         end
      end
      send_byte(c ^ flip, gap);
   endtask

   task automatic check_reset(input string tag);
      check_val({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd1);
      check_val({tag, "_mem_we"},    {31'd0, bus.mem_we},    32'd0);
      check_val({tag, "_mem_addr"},  32'(bus.mem_addr),      32'd0);
      check_val({tag, "_mem_wdata"}, bus.mem_wdata,          32'd0);
      check_val({tag, "_cpu_start"}, {31'd0, bus.cpu_start}, 32'd0);
      check_val({tag, "_cpu_pc"},    bus.cpu_pc,             32'd0);
      check_val({tag, "_busy"},      {31'd0, bus.busy},      32'd0);
      check_val({tag, "_done"},      {31'd0, bus.done},      32'd0);
      check_val({tag, "_err"},       {31'd0, bus.err},       32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] fr1 [0:9];
      logic [7:0] fr0 [0:5];
      fr1 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h28, 8'h0A, 8'h00, 8'hC8, 8'hEB};
      fr0 = '{8'hA5, 8'h00, 8'h05, 8'h00, 8'h00, 8'h05};
      words[0]  = 32'h280a00c8; words[1]  = 32'h28020001; words[2]  = 32'h0e94a000;
      words[3]  = 32'h21430000; words[4]  = 32'h0e94a000; words[5]  = 32'h14431000;
      words[6]  = 32'h2c630001; words[7]  = 32'h0e94a000; words[8]  = 32'h3460fffc;
      words[9]  = 32'h2542fffe; words[10] = 32'hfc000000; words[11] = 32'hdeadbeef;
      for (int i = 12; i < 16; i++) words[i] = 32'd0;

      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;

      // Single word with hand-computed checksum EB.
      w0 = wr_addr_q.size(); s0 = start_cnt;
      for (int i = 0; i < 10; i++) send_byte(fr1[i], 0);
      repeat (4) @(negedge clk);
      check_val("one_nwrites", 32'(wr_addr_q.size() - w0), 32'd1);
      check_val("one_addr", 32'(wr_addr_q[w0]), 32'd0);
      check_val("one_data", wr_data_q[w0], 32'h280a00c8);
      check_val("one_nstart", 32'(start_cnt - s0), 32'd1);
      check_val("one_start_lat", 32'(start_cyc - wr_cyc_q[w0]), 32'd1);
      check_val("one_pc", start_pc, 32'd0);
      check_val("one_done", {31'd0, bus.done}, 32'd1);
      check_val("one_err", {31'd0, bus.err}, 32'd0);
      check_val("one_busy", {31'd0, bus.busy}, 32'd0);

      // Full factorial program at base 0.
      w0 = wr_addr_q.size(); s0 = start_cnt;
      send_frame(16'h0000, 16'd11, 0, 8'h00, 0);
      repeat (4) @(negedge clk);
      check_val("fact_nwrites", 32'(wr_addr_q.size() - w0), 32'd11);
      for (int i = 0; i < 11; i++) begin
         if (w0 + i < wr_addr_q.size()) begin
            check_val($sformatf("fact_addr%0d", i), 32'(wr_addr_q[w0+i]), 32'(i));
            check_val($sformatf("fact_data%0d", i), wr_data_q[w0+i], words[i]);
         end
      end
      check_val("fact_nstart", 32'(start_cnt - s0), 32'd1);
      check_val("fact_pc", start_pc, 32'd0);
      check_val("fact_done", {31'd0, bus.done}, 32'd1);

      // Bad checksum EA: write lands, no start, err set.
      w0 = wr_addr_q.size(); s0 = start_cnt;
      for (int i = 0; i < 9; i++) send_byte(fr1[i], 0);
      send_byte(8'hEA, 0);
      repeat (4) @(negedge clk);
      check_val("badchk_nwrites", 32'(wr_addr_q.size() - w0), 32'd1);
      check_val("badchk_data", wr_data_q[w0], 32'h280a00c8);
      check_val("badchk_nstart", 32'(start_cnt - s0), 32'd0);
      check_val("badchk_err", {31'd0, bus.err}, 32'd1);
      check_val("badchk_done", {31'd0, bus.done}, 32'd0);
      check_val("badchk_busy", {31'd0, bus.busy}, 32'd0);

      // Range overflow: 2016 + 9 > 2024, rest of frame discarded.
      w0 = wr_addr_q.size(); s0 = start_cnt;
      send_byte(8'hA5, 0); send_byte(8'h07, 0); send_byte(8'hE0, 0);
      send_byte(8'h00, 0); send_byte(8'h09, 0);
      repeat (2) @(negedge clk);
      check_val("range_err", {31'd0, bus.err}, 32'd1);
      check_val("range_busy", {31'd0, bus.busy}, 32'd0);
      for (int i = 0; i < 12; i++) send_byte(8'(8'h11 + i), 0);
      repeat (3) @(negedge clk);
      check_val("range_nwrites", 32'(wr_addr_q.size() - w0), 32'd0);
      check_val("range_nstart", 32'(start_cnt - s0), 32'd0);
      check_val("range_err_held", {31'd0, bus.err}, 32'd1);

      // Range boundary: 2016 + 8 == 2024 is legal, last address 2023.
      w0 = wr_addr_q.size(); s0 = start_cnt;
      send_frame(16'h07E0, 16'd8, 0, 8'h00, 0);
      repeat (4) @(negedge clk);
      check_val("edge_nwrites", 32'(wr_addr_q.size() - w0), 32'd8);
      check_val("edge_first", 32'(wr_addr_q[w0]), 32'd2016);
      check_val("edge_last", 32'(wr_addr_q[w0+7]), 32'd2023);
      check_val("edge_pc", start_pc, 32'd2016);
      check_val("edge_done", {31'd0, bus.done}, 32'd1);
      check_val("edge_err", {31'd0, bus.err}, 32'd0);

      // Zero-count frame.
      w0 = wr_addr_q.size(); s0 = start_cnt;
      for (int i = 0; i < 6; i++) send_byte(fr0[i], 0);
      repeat (4) @(negedge clk);
      check_val("cnt0_nwrites", 32'(wr_addr_q.size() - w0), 32'd0);
      check_val("cnt0_nstart", 32'(start_cnt - s0), 32'd1);
      check_val("cnt0_pc", start_pc, 32'd5);
      check_val("cnt0_done", {31'd0, bus.done}, 32'd1);

      // Garbage, gapped stream, reset after two words of a four-word frame.
      w0 = wr_addr_q.size(); s0 = start_cnt;
      send_byte(8'h00, 1); send_byte(8'hFF, 0); send_byte(8'h12, 2);
      send_byte(8'hA5, 1); send_byte(8'h00, 0); send_byte(8'h40, 2);
      send_byte(8'h00, 1); send_byte(8'h04, 0);
      for (int i = 0; i < 10; i++) send_byte(words[i/4][(3 - i%4)*8 +: 8], i % 3);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset("midrst");
      repeat (4) @(negedge clk);
      check_reset("midrst_hold");
      check_val("midrst_nwrites", 32'(wr_addr_q.size() - w0), 32'd2);
      check_val("midrst_addr0", 32'(wr_addr_q[w0]), 32'h40);
      check_val("midrst_addr1", 32'(wr_addr_q[w0+1]), 32'h41);
      check_val("midrst_data1", wr_data_q[w0+1], words[1]);
      check_val("midrst_nstart", 32'(start_cnt - s0), 32'd0);
      rst = 1'b0;

      // Fresh frame after reset.
      w0 = wr_addr_q.size(); s0 = start_cnt;
      send_frame(16'h0003, 16'd1, 11, 8'h00, 1);
      repeat (4) @(negedge clk);
      check_val("fresh_nwrites", 32'(wr_addr_q.size() - w0), 32'd1);
      check_val("fresh_addr", 32'(wr_addr_q[w0]), 32'd3);
      check_val("fresh_data", wr_data_q[w0], 32'hdeadbeef);
      check_val("fresh_pc", start_pc, 32'd3);
      check_val("fresh_done", {31'd0, bus.done}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
